age_ordered_reservation_station: RTL

- Parametrised successor to the single-CDB ALU reservation station.
- Holds dispatched ops until both source operands are available, then issues the oldest ready entry to the functional unit.
- Generalised in depth, data/tag/control widths and number of common-data-bus lanes.
- Adds features the previous generation lacks:
  - valid/ready handshakes on both the dispatch and issue sides;
  - same-cycle CDB capture at dispatch;
  - true age-ordered selection;
  - an occupancy counter.
- Sits between rename/dispatch and an execution unit.

---
 rtl/age_ordered_reservation_station_if.sv | 50 +++++
 rtl/age_ordered_reservation_station.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/age_ordered_reservation_station_if.sv
// Dispatch, broadcast and issue signals of the age-ordered reservation station.
// The master side is the rename/dispatch + CDB + execution-unit environment;
// the slave side is the station itself.
interface age_ordered_reservation_station_if #(
    parameter int DEPTH   = 8,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 6,
    parameter int CTL_W   = 5,
    parameter int NUM_CDB = 2
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic                        flush;
    logic                        disp_valid;
    logic                        disp_ready;
    logic [CTL_W-1:0]            disp_ctl;
    logic [TAG_W-1:0]            disp_tag;
    logic                        disp_src1_rdy;
    logic [TAG_W-1:0]            disp_src1_tag;
    logic [DATA_W-1:0]           disp_src1_val;
    logic                        disp_src2_rdy;
    logic [TAG_W-1:0]            disp_src2_tag;
    logic [DATA_W-1:0]           disp_src2_val;
    logic [NUM_CDB-1:0]          cdb_valid;
    logic [NUM_CDB*TAG_W-1:0]    cdb_tag;
    logic [NUM_CDB*DATA_W-1:0]   cdb_data;
    logic                        iss_valid;
    logic                        iss_ready;
    logic [CTL_W-1:0]            iss_ctl;
    logic [TAG_W-1:0]            iss_tag;
    logic [DATA_W-1:0]           iss_op1;
    logic [DATA_W-1:0]           iss_op2;
    logic [OCC_W-1:0]            occupancy;

    modport master (
        output flush, disp_valid, disp_ctl, disp_tag,
               disp_src1_rdy, disp_src1_tag, disp_src1_val,
               disp_src2_rdy, disp_src2_tag, disp_src2_val,
               cdb_valid, cdb_tag, cdb_data, iss_ready,
        input  disp_ready, iss_valid, iss_ctl, iss_tag, iss_op1, iss_op2, occupancy
    );

    modport slave (
        input  flush, disp_valid, disp_ctl, disp_tag,
               disp_src1_rdy, disp_src1_tag, disp_src1_val,
               disp_src2_rdy, disp_src2_tag, disp_src2_val,
               cdb_valid, cdb_tag, cdb_data, iss_ready,
        output disp_ready, iss_valid, iss_ctl, iss_tag, iss_op1, iss_op2, occupancy
    );
endinterface

// File: rtl/age_ordered_reservation_station.sv
// Age-ordered reservation station: holds dispatched ops until both operands
// are available (via dispatch, same-cycle CDB bypass or later CDB wakeup) and
// issues the oldest ready entry. Relative age is tracked with a DEPTH x DEPTH
// matrix, older_r[i][j] = 1 meaning entry i is older than entry j.
module age_ordered_reservation_station #(
    parameter int DEPTH   = 8,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 6,
    parameter int CTL_W   = 5,
    parameter int NUM_CDB = 2
) (
    input  logic clk,
    input  logic rst,
    age_ordered_reservation_station_if.slave rs
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int OCC_W = IDX_W + 1;

    typedef struct packed {
        logic              hit;
        logic [DATA_W-1:0] data;
    } cdb_hit_t;

    // Searches all CDB lanes for a tag; the lowest matching lane index wins.
    function automatic cdb_hit_t cdb_lookup(
        input logic [TAG_W-1:0]          tag,
        input logic [NUM_CDB-1:0]        vld,
        input logic [NUM_CDB*TAG_W-1:0]  tags,
        input logic [NUM_CDB*DATA_W-1:0] data
    );
        cdb_hit_t res;
        res = '0;
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            res = (vld[k] && (tags[k*TAG_W +: TAG_W] == tag)) ?
                  {1'b1, data[k*DATA_W +: DATA_W]} : res;
        end
        return res;
    endfunction

    // Entry state
    logic                valid_r  [DEPTH];
    logic [CTL_W-1:0]    ctl_r    [DEPTH];
    logic [TAG_W-1:0]    tag_r    [DEPTH];
    logic                s1_rdy_r [DEPTH];
    logic [TAG_W-1:0]    s1_tag_r [DEPTH];
    logic [DATA_W-1:0]   s1_val_r [DEPTH];
    logic                s2_rdy_r [DEPTH];
    logic [TAG_W-1:0]    s2_tag_r [DEPTH];
    logic [DATA_W-1:0]   s2_val_r [DEPTH];
    logic [DEPTH-1:0]    older_r  [DEPTH];
    logic [OCC_W-1:0]    occ_r;

    // Combinational helpers
    cdb_hit_t            w1_s [DEPTH];
    cdb_hit_t            w2_s [DEPTH];
    cdb_hit_t            d1_s;
    cdb_hit_t            d2_s;
    logic [DEPTH-1:0]    cand_s;
    logic [DEPTH-1:0]    oldest_s;
    logic [IDX_W-1:0]    sel_idx_s;
    logic [IDX_W-1:0]    free_idx_s;
    logic                iss_valid_s;
    logic                iss_fire_s;
    logic                disp_ready_s;
    logic                disp_fire_s;

    // CDB lookups for every waiting source and for the incoming dispatch.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w1_s[i] = cdb_lookup(s1_tag_r[i], rs.cdb_valid, rs.cdb_tag, rs.cdb_data);
            w2_s[i] = cdb_lookup(s2_tag_r[i], rs.cdb_valid, rs.cdb_tag, rs.cdb_data);
        end
        d1_s = cdb_lookup(rs.disp_src1_tag, rs.cdb_valid, rs.cdb_tag, rs.cdb_data);
        d2_s = cdb_lookup(rs.disp_src2_tag, rs.cdb_valid, rs.cdb_tag, rs.cdb_data);
    end

    // Oldest-ready pick: a candidate wins when no other candidate is older than it.
    always_comb begin
        cand_s    = '0;
        oldest_s  = '0;
        sel_idx_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cand_s[i] = valid_r[i] & s1_rdy_r[i] & s2_rdy_r[i];
        end
        for (int i = 0; i < DEPTH; i++) begin
            oldest_s[i] = cand_s[i];
            for (int j = 0; j < DEPTH; j++) begin
                oldest_s[i] = oldest_s[i] & ~(cand_s[j] & older_r[j][i]);
            end
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            sel_idx_s = oldest_s[i] ? IDX_W'(i) : sel_idx_s;
        end
    end

    // Lowest-index free slot for a new dispatch.
    always_comb begin
        free_idx_s = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            free_idx_s = (!valid_r[i]) ? IDX_W'(i) : free_idx_s;
        end
    end

    assign iss_valid_s  = |cand_s;
    assign iss_fire_s   = iss_valid_s & rs.iss_ready;
    assign disp_ready_s = (occ_r < OCC_W'(DEPTH));
    assign disp_fire_s  = rs.disp_valid & disp_ready_s & ~rs.flush;

    assign rs.disp_ready = disp_ready_s;
    assign rs.occupancy  = occ_r;
    assign rs.iss_valid  = iss_valid_s;
    assign rs.iss_ctl    = iss_valid_s ? ctl_r[sel_idx_s]    : '0;
    assign rs.iss_tag    = iss_valid_s ? tag_r[sel_idx_s]    : '0;
    assign rs.iss_op1    = iss_valid_s ? s1_val_r[sel_idx_s] : '0;
    assign rs.iss_op2    = iss_valid_s ? s2_val_r[sel_idx_s] : '0;

    // Entry, age-matrix and occupancy update: flush beats wakeup, issue and dispatch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_r[i]  <= 1'b0;
                ctl_r[i]    <= '0;
                tag_r[i]    <= '0;
                s1_rdy_r[i] <= 1'b0;
                s1_tag_r[i] <= '0;
                s1_val_r[i] <= '0;
                s2_rdy_r[i] <= 1'b0;
                s2_tag_r[i] <= '0;
                s2_val_r[i] <= '0;
                older_r[i]  <= '0;
            end
            occ_r <= '0;
        end else if (rs.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_r[i] <= 1'b0;
                older_r[i] <= '0;
            end
            occ_r <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_r[i] && !s1_rdy_r[i] && w1_s[i].hit) begin
                    s1_rdy_r[i] <= 1'b1;
                    s1_val_r[i] <= w1_s[i].data;
                end
                if (valid_r[i] && !s2_rdy_r[i] && w2_s[i].hit) begin
                    s2_rdy_r[i] <= 1'b1;
                    s2_val_r[i] <= w2_s[i].data;
                end
            end
            if (iss_fire_s) begin
                valid_r[sel_idx_s] <= 1'b0;
            end
            if (disp_fire_s) begin
                valid_r[free_idx_s]  <= 1'b1;
                ctl_r[free_idx_s]    <= rs.disp_ctl;
                tag_r[free_idx_s]    <= rs.disp_tag;
                s1_tag_r[free_idx_s] <= rs.disp_src1_tag;
                s1_rdy_r[free_idx_s] <= rs.disp_src1_rdy | d1_s.hit;
                s1_val_r[free_idx_s] <= rs.disp_src1_rdy ? rs.disp_src1_val : d1_s.data;
                s2_tag_r[free_idx_s] <= rs.disp_src2_tag;
                s2_rdy_r[free_idx_s] <= rs.disp_src2_rdy | d2_s.hit;
                s2_val_r[free_idx_s] <= rs.disp_src2_rdy ? rs.disp_src2_val : d2_s.data;
                // New entry is younger than everything currently held.
                older_r[free_idx_s]  <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    older_r[i][free_idx_s] <= valid_r[i];
                end
            end
            occ_r <= occ_r + OCC_W'(disp_fire_s) - OCC_W'(iss_fire_s);
        end
    end
endmodule
